// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter: data port (M0) and fetch port (M1) share one slave.
// Grant is registered, the bus mux is combinational; a stalled strobe can be aborted.
module wb_master_arbiter #(
    parameter int unsigned TIMEOUT = 255,
    parameter bit          RR      = 1'b1
) (
    input  logic        CLK_I,
    input  logic        RST_I,

    input  logic        M0_CYC_I,
    input  logic        M0_STB_I,
    input  logic        M0_WE_I,
    input  logic [3:0]  M0_SEL_I,
    input  logic [31:0] M0_ADR_I,
    input  logic [31:0] M0_DAT_I,
    output logic [31:0] M0_DAT_O,
    output logic        M0_ACK_O,
    output logic        M0_ERR_O,

    input  logic        M1_CYC_I,
    input  logic        M1_STB_I,
    input  logic        M1_WE_I,
    input  logic [3:0]  M1_SEL_I,
    input  logic [31:0] M1_ADR_I,
    input  logic [31:0] M1_DAT_I,
    output logic [31:0] M1_DAT_O,
    output logic        M1_ACK_O,
    output logic        M1_ERR_O,

    output logic        S_CYC_O,
    output logic        S_STB_O,
    output logic        S_WE_O,
    output logic [3:0]  S_SEL_O,
    output logic [31:0] S_ADR_O,
    output logic [31:0] S_DAT_O,
    input  logic [31:0] S_DAT_I,
    input  logic        S_ACK_I,

    output logic [1:0]  GNT_O
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1,
        ABORT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          last;
    logic          last_nxt;
    logic          ab_owner;
    logic          ab_owner_nxt;
    logic          err_pend;
    logic          err_pend_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    logic own_cyc;
    logic own_stb;
    logic ab_cyc;
    logic tmo_hit;

    assign own_cyc = (state == OWN1) ? M1_CYC_I : M0_CYC_I;
    assign own_stb = (state == OWN1) ? M1_STB_I : M0_STB_I;
    assign ab_cyc  = ab_owner ? M1_CYC_I : M0_CYC_I;
    assign tmo_hit = (TIMEOUT != 0) && (cnt == LIMIT);

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state    <= IDLE;
            last     <= 1'b1;
            ab_owner <= 1'b0;
            err_pend <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            ab_owner <= ab_owner_nxt;
            err_pend <= err_pend_nxt;
            cnt      <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        ab_owner_nxt = ab_owner;
        err_pend_nxt = 1'b0;
        cnt_nxt      = '0;
        unique case (state)
            IDLE: begin
                // On a tie, RR hands the bus to whoever did not have it last
                if (M0_CYC_I && M1_CYC_I) begin
                    if (RR && !last) begin
                        state_nxt = OWN1;
                        last_nxt  = 1'b1;
                    end else begin
                        state_nxt = OWN0;
                        last_nxt  = 1'b0;
                    end
                end else if (M0_CYC_I) begin
                    state_nxt = OWN0;
                    last_nxt  = 1'b0;
                end else if (M1_CYC_I) begin
                    state_nxt = OWN1;
                    last_nxt  = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (!own_cyc) begin
                    state_nxt = IDLE;
                end else if (S_ACK_I || !own_stb) begin
                    cnt_nxt = '0;
                end else if (tmo_hit) begin
                    state_nxt    = ABORT;
                    ab_owner_nxt = (state == OWN1);
                    err_pend_nxt = 1'b1;
                end else if (cnt != {CW{1'b1}}) begin
                    cnt_nxt = cnt + CW'(1);
                end else begin
                    cnt_nxt = cnt;
                end
            end
            ABORT: begin
                if (!ab_cyc) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    assign M0_DAT_O = S_DAT_I;
    assign M1_DAT_O = S_DAT_I;

    always_comb begin
        S_CYC_O  = 1'b0;
        S_STB_O  = 1'b0;
        S_WE_O   = 1'b0;
        S_SEL_O  = '0;
        S_ADR_O  = '0;
        S_DAT_O  = '0;
        M0_ACK_O = 1'b0;
        M1_ACK_O = 1'b0;
        M0_ERR_O = 1'b0;
        M1_ERR_O = 1'b0;
        GNT_O    = 2'b00;
        unique case (state)
            IDLE: begin
            end
            OWN0: begin
                S_CYC_O  = M0_CYC_I;
                S_STB_O  = M0_STB_I;
                S_WE_O   = M0_WE_I;
                S_SEL_O  = M0_SEL_I;
                S_ADR_O  = M0_ADR_I;
                S_DAT_O  = M0_DAT_I;
                M0_ACK_O = S_ACK_I;
                GNT_O    = 2'b01;
            end
            OWN1: begin
                S_CYC_O  = M1_CYC_I;
                S_STB_O  = M1_STB_I;
                S_WE_O   = M1_WE_I;
                S_SEL_O  = M1_SEL_I;
                S_ADR_O  = M1_ADR_I;
                S_DAT_O  = M1_DAT_I;
                M1_ACK_O = S_ACK_I;
                GNT_O    = 2'b10;
            end
            ABORT: begin
                // Bus is released to the slave; the owner keeps the grant until it drops CYC
                M0_ERR_O = err_pend && !ab_owner;
                M1_ERR_O = err_pend && ab_owner;
                GNT_O    = ab_owner ? 2'b10 : 2'b01;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: cycle table on a TIMEOUT=4 RR instance,
// plus sequences on a fixed-priority instance with the timeout disabled.
module tb_wb_master_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        c0, s0, w0, c1, s1, ack;
    logic [31:0] sdat;

    logic [31:0] a_dat0, a_dat1, a_adr, a_sdo;
    logic        a_ack0, a_ack1, a_err0, a_err1;
    logic        a_cyc, a_stb, a_we;
    logic [3:0]  a_sel;
    logic [1:0]  a_gnt;

    logic [31:0] f_dat0, f_dat1, f_adr, f_sdo;
    logic        f_ack0, f_ack1, f_err0, f_err1;
    logic        f_cyc, f_stb, f_we;
    logic [3:0]  f_sel;
    logic [1:0]  f_gnt;

    int checks = 0;
    int errors = 0;

    wb_master_arbiter #(.TIMEOUT(4), .RR(1'b1)) dut (
        .CLK_I(clk), .RST_I(rst),
        .M0_CYC_I(c0), .M0_STB_I(s0), .M0_WE_I(w0), .M0_SEL_I(4'hF),
        .M0_ADR_I(32'h0000_1000), .M0_DAT_I(32'h0000_00A0),
        .M0_DAT_O(a_dat0), .M0_ACK_O(a_ack0), .M0_ERR_O(a_err0),
        .M1_CYC_I(c1), .M1_STB_I(s1), .M1_WE_I(1'b0), .M1_SEL_I(4'h3),
        .M1_ADR_I(32'h0000_2000), .M1_DAT_I(32'h0000_00B1),
        .M1_DAT_O(a_dat1), .M1_ACK_O(a_ack1), .M1_ERR_O(a_err1),
        .S_CYC_O(a_cyc), .S_STB_O(a_stb), .S_WE_O(a_we), .S_SEL_O(a_sel),
        .S_ADR_O(a_adr), .S_DAT_O(a_sdo), .S_DAT_I(sdat), .S_ACK_I(ack),
        .GNT_O(a_gnt)
    );

    wb_master_arbiter #(.TIMEOUT(0), .RR(1'b0)) dut_fp (
        .CLK_I(clk), .RST_I(rst),
        .M0_CYC_I(c0), .M0_STB_I(s0), .M0_WE_I(w0), .M0_SEL_I(4'hF),
        .M0_ADR_I(32'h0000_1000), .M0_DAT_I(32'h0000_00A0),
        .M0_DAT_O(f_dat0), .M0_ACK_O(f_ack0), .M0_ERR_O(f_err0),
        .M1_CYC_I(c1), .M1_STB_I(s1), .M1_WE_I(1'b0), .M1_SEL_I(4'h3),
        .M1_ADR_I(32'h0000_2000), .M1_DAT_I(32'h0000_00B1),
        .M1_DAT_O(f_dat1), .M1_ACK_O(f_ack1), .M1_ERR_O(f_err1),
        .S_CYC_O(f_cyc), .S_STB_O(f_stb), .S_WE_O(f_we), .S_SEL_O(f_sel),
        .S_ADR_O(f_adr), .S_DAT_O(f_sdo), .S_DAT_I(sdat), .S_ACK_I(ack),
        .GNT_O(f_gnt)
    );

    // in: {rst,c0,s0,w0,c1,s1,ack}
    // ex: {gnt[1:0],check_gnt,scyc,sstb,swe,ack0,ack1,err0,err1}
    typedef struct {
        logic [6:0]  in;
        logic [31:0] sdat;
        logic [9:0]  ex;
        logic [31:0] adr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [6:0] i, logic [31:0] d,
                                logic [9:0] e, logic [31:0] a);
        vec_t v;
        v.in   = i;
        v.sdat = d;
        v.ex   = e;
        v.adr  = a;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        c0 = 1'b0; s0 = 1'b0; w0 = 1'b0;
        c1 = 1'b0; s1 = 1'b0; ack = 1'b0;
        sdat = 32'h0;

        // reset with a pending request, then M0 single read
        tbl.push_back(mk(7'b1_110_00_0, 32'h1111_1111, 10'b00_1_000_0000, 32'h0));
        tbl.push_back(mk(7'b0_110_00_0, 32'h0,         10'b00_1_000_0000, 32'h0));
        tbl.push_back(mk(7'b0_110_00_0, 32'h0,         10'b01_1_110_0000, 32'h1000));
        tbl.push_back(mk(7'b0_110_00_0, 32'h0,         10'b01_1_110_0000, 32'h1000));
        tbl.push_back(mk(7'b0_110_00_1, 32'hDEAD_BEEF, 10'b01_1_110_1000, 32'h1000));
        tbl.push_back(mk(7'b0_000_00_0, 32'h0,         10'b01_1_000_0000, 32'h1000));
        tbl.push_back(mk(7'b0_000_00_0, 32'h0,         10'b00_1_000_0000, 32'h0));
        // round-robin with both requesting
        tbl.push_back(mk(7'b0_110_11_0, 32'h0,         10'b00_1_000_0000, 32'h0));
        tbl.push_back(mk(7'b0_110_11_1, 32'h2222_0001, 10'b10_1_110_0100, 32'h2000));
        tbl.push_back(mk(7'b0_110_00_0, 32'h0,         10'b10_1_000_0000, 32'h2000));
        tbl.push_back(mk(7'b0_110_11_1, 32'h0,         10'b00_1_000_0000, 32'h0));
        tbl.push_back(mk(7'b0_110_11_1, 32'h2222_0002, 10'b01_1_110_1000, 32'h1000));
        tbl.push_back(mk(7'b0_000_11_0, 32'h0,         10'b01_1_000_0000, 32'h1000));
        tbl.push_back(mk(7'b0_110_11_0, 32'h0,         10'b00_1_000_0000, 32'h0));
        tbl.push_back(mk(7'b0_110_11_1, 32'h2222_0003, 10'b10_1_110_0100, 32'h2000));
        tbl.push_back(mk(7'b0_000_00_0, 32'h0,         10'b10_1_000_0000, 32'h2000));
        tbl.push_back(mk(7'b0_000_00_0, 32'h0,         10'b00_1_000_0000, 32'h0));
        // M1 never acknowledged: abort after four strobe cycles
        tbl.push_back(mk(7'b0_000_11_0, 32'h0,         10'b00_1_000_0000, 32'h0));
        tbl.push_back(mk(7'b0_000_11_0, 32'h0,         10'b10_1_110_0000, 32'h2000));
        tbl.push_back(mk(7'b0_000_11_0, 32'h0,         10'b10_1_110_0000, 32'h2000));
        tbl.push_back(mk(7'b0_000_11_0, 32'h0,         10'b10_1_110_0000, 32'h2000));
        tbl.push_back(mk(7'b0_000_11_0, 32'h0,         10'b10_1_110_0000, 32'h2000));
        tbl.push_back(mk(7'b0_000_11_1, 32'h0,         10'b00_0_000_0001, 32'h0));
        tbl.push_back(mk(7'b0_000_11_0, 32'h0,         10'b00_0_000_0000, 32'h0));
        tbl.push_back(mk(7'b0_000_00_0, 32'h0,         10'b00_0_000_0000, 32'h0));
        tbl.push_back(mk(7'b0_000_00_0, 32'h0,         10'b00_1_000_0000, 32'h0));
        // ack on the last allowed wait cycle, two beats, M1 waiting
        tbl.push_back(mk(7'b0_110_00_0, 32'h0,         10'b00_1_000_0000, 32'h0));
        tbl.push_back(mk(7'b0_110_00_0, 32'h0,         10'b01_1_110_0000, 32'h1000));
        tbl.push_back(mk(7'b0_110_00_0, 32'h0,         10'b01_1_110_0000, 32'h1000));
        tbl.push_back(mk(7'b0_110_00_0, 32'h0,         10'b01_1_110_0000, 32'h1000));
        tbl.push_back(mk(7'b0_110_00_1, 32'hCAFE_F00D, 10'b01_1_110_1000, 32'h1000));
        tbl.push_back(mk(7'b0_100_11_0, 32'h0,         10'b01_1_100_0000, 32'h1000));
        tbl.push_back(mk(7'b0_110_11_0, 32'h0,         10'b01_1_110_0000, 32'h1000));
        tbl.push_back(mk(7'b0_110_11_0, 32'h0,         10'b01_1_110_0000, 32'h1000));
        tbl.push_back(mk(7'b0_110_11_0, 32'h0,         10'b01_1_110_0000, 32'h1000));
        tbl.push_back(mk(7'b0_110_11_1, 32'h3333_0001, 10'b01_1_110_1000, 32'h1000));
        tbl.push_back(mk(7'b0_000_11_0, 32'h0,         10'b01_1_000_0000, 32'h1000));
        tbl.push_back(mk(7'b0_000_11_0, 32'h0,         10'b00_1_000_0000, 32'h0));
        tbl.push_back(mk(7'b0_000_00_0, 32'h0,         10'b10_1_000_0000, 32'h2000));
        // reset in the middle of an M0 write; first tie afterwards goes to M0
        tbl.push_back(mk(7'b0_111_00_0, 32'h0,         10'b00_1_000_0000, 32'h0));
        tbl.push_back(mk(7'b1_111_00_0, 32'h0,         10'b01_1_111_0000, 32'h1000));
        tbl.push_back(mk(7'b0_111_11_1, 32'h0,         10'b00_1_000_0000, 32'h0));
        tbl.push_back(mk(7'b0_111_11_0, 32'h0,         10'b01_1_111_0000, 32'h1000));
        tbl.push_back(mk(7'b0_000_11_0, 32'h0,         10'b01_1_000_0000, 32'h1000));
        tbl.push_back(mk(7'b0_000_11_0, 32'h0,         10'b00_1_000_0000, 32'h0));
        tbl.push_back(mk(7'b0_000_00_0, 32'h0,         10'b10_1_000_0000, 32'h2000));
        tbl.push_back(mk(7'b0_000_00_0, 32'h0,         10'b00_1_000_0000, 32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            {rst, c0, s0, w0, c1, s1, ack} = tbl[i].in;
            sdat = tbl[i].sdat;
            #1;
            if (tbl[i].ex[7])
                chk("gnt", i, 32'(a_gnt), 32'(tbl[i].ex[9:8]));
            chk("s_cyc", i, 32'(a_cyc),  32'(tbl[i].ex[6]));
            chk("s_stb", i, 32'(a_stb),  32'(tbl[i].ex[5]));
            chk("s_we",  i, 32'(a_we),   32'(tbl[i].ex[4]));
            chk("ack0",  i, 32'(a_ack0), 32'(tbl[i].ex[3]));
            chk("ack1",  i, 32'(a_ack1), 32'(tbl[i].ex[2]));
            chk("err0",  i, 32'(a_err0), 32'(tbl[i].ex[1]));
            chk("err1",  i, 32'(a_err1), 32'(tbl[i].ex[0]));
            chk("s_adr", i, a_adr,  tbl[i].adr);
            chk("dat0",  i, a_dat0, tbl[i].sdat);
            chk("dat1",  i, a_dat1, tbl[i].sdat);
        end

        // fixed priority: M0 keeps winning while both request
        @(negedge clk);
        {rst, c0, s0, w0, c1, s1, ack} = 7'b0;
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            c0 = 1'b1; s0 = 1'b1; c1 = 1'b1; s1 = 1'b1; ack = 1'b0;
            #1;
            chk("fp_idle", r, 32'(f_gnt), 32'h0);
            @(negedge clk);
            ack = 1'b1;
            #1;
            chk("fp_gnt",  r, 32'(f_gnt),  32'h1);
            chk("fp_ack0", r, 32'(f_ack0), 32'h1);
            chk("fp_ack1", r, 32'(f_ack1), 32'h0);
            chk("fp_sadr", r, f_adr, 32'h1000);
            @(negedge clk);
            c0 = 1'b0; s0 = 1'b0; ack = 1'b0;
            #1;
            chk("fp_drop", r, 32'(f_gnt), 32'h1);
        end

        // timeout disabled: a long unacknowledged strobe keeps the bus
        @(negedge clk);
        {rst, c0, s0, w0, c1, s1, ack} = 7'b0;
        @(negedge clk);
        c1 = 1'b1; s1 = 1'b1;
        #1;
        chk("fp_req", 0, 32'(f_gnt), 32'h0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk("fp_hold_gnt", k, 32'(f_gnt),  32'h2);
            chk("fp_hold_cyc", k, 32'(f_cyc),  32'h1);
            chk("fp_hold_err", k, 32'(f_err1), 32'h0);
        end
        @(negedge clk);
        c1 = 1'b0; s1 = 1'b0;
        @(negedge clk);
        #1;
        chk("fp_release", 0, 32'(f_gnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
